// File: rtl/execute.sv
// Execute stage of the RV32IM pipeline: ALU, multiplier, branch resolution and an iterative
// radix-2 restoring divider, with all results registered toward mem_access.
module execute #(
  parameter bit         DIV_EN        = 1'b1,
  parameter logic [4:0] BUBBLE_OPCODE = 5'b00100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [4:0]  opcode_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  input  logic [4:0]  rd_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] rs1_data_i,
  input  logic [31:0] rs2_data_i,
  input  logic [31:0] imm_i,
  output logic        valid_o,
  output logic [4:0]  opcode_o,
  output logic [4:0]  rd_o,
  output logic [31:0] alu_result_o,
  output logic [31:0] data_o,
  output logic        branch_taken_o,
  output logic [31:0] branch_target_o
);

  localparam logic [4:0] OpcLoad   = 5'b00000;
  localparam logic [4:0] OpcStore  = 5'b01000;
  localparam logic [4:0] OpcOpImm  = 5'b00100;
  localparam logic [4:0] OpcOp     = 5'b01100;
  localparam logic [4:0] OpcLui    = 5'b01101;
  localparam logic [4:0] OpcAuipc  = 5'b00101;
  localparam logic [4:0] OpcJal    = 5'b11011;
  localparam logic [4:0] OpcJalr   = 5'b11001;
  localparam logic [4:0] OpcBranch = 5'b11000;

  localparam logic StIdle = 1'b0;
  localparam logic StBusy = 1'b1;

  logic        state_q;
  logic [4:0]  cnt_q;
  logic [31:0] quo_q, rem_q, dvs_q, div_data_q;
  logic [4:0]  div_opc_q, div_rd_q;
  logic        neg_quo_q, neg_rem_q, want_rem_q, div_zero_q;

  logic        is_op, is_m, is_div, sgn_div, a_neg, b_neg;
  logic [31:0] op_b, alu_res, sra_res, mul_res, res, target;
  logic [4:0]  shamt;
  logic        br_cond, taken;
  logic [32:0] mul_a, mul_b;
  logic signed [65:0] prod;
  logic        unused_prod;

  assign ready_o = (state_q == StIdle);
  assign is_op   = (opcode_i == OpcOp);
  assign is_m    = is_op && (funct7_i == 7'b0000001);
  assign is_div  = is_m && funct3_i[2];
  assign op_b    = is_op ? rs2_data_i : imm_i;
  assign shamt   = op_b[4:0];
  assign sra_res = $signed(rs1_data_i) >>> shamt;

  // MULH/MULHSU need signed operands; a 33-bit signed multiply covers all four variants.
  assign mul_a   = {((funct3_i == 3'b001) || (funct3_i == 3'b010)) & rs1_data_i[31], rs1_data_i};
  assign mul_b   = {(funct3_i == 3'b001) & rs2_data_i[31], rs2_data_i};
  assign prod    = $signed(mul_a) * $signed(mul_b);
  assign mul_res = (funct3_i == 3'b000) ? prod[31:0] : prod[63:32];
  assign unused_prod = ^prod[65:64];

  always_comb begin
    alu_res = '0;
    case (funct3_i)
      3'b000:  alu_res = (is_op && funct7_i[5]) ? rs1_data_i - op_b : rs1_data_i + op_b;
      3'b001:  alu_res = rs1_data_i << shamt;
      3'b010:  alu_res = {31'b0, $signed(rs1_data_i) < $signed(op_b)};
      3'b011:  alu_res = {31'b0, rs1_data_i < op_b};
      3'b100:  alu_res = rs1_data_i ^ op_b;
      3'b101:  alu_res = funct7_i[5] ? sra_res : rs1_data_i >> shamt;
      3'b110:  alu_res = rs1_data_i | op_b;
      default: alu_res = rs1_data_i & op_b;
    endcase
  end

  always_comb begin
    br_cond = 1'b0;
    case (funct3_i)
      3'b000:  br_cond = rs1_data_i == rs2_data_i;
      3'b001:  br_cond = rs1_data_i != rs2_data_i;
      3'b100:  br_cond = $signed(rs1_data_i) < $signed(rs2_data_i);
      3'b101:  br_cond = $signed(rs1_data_i) >= $signed(rs2_data_i);
      3'b110:  br_cond = rs1_data_i < rs2_data_i;
      3'b111:  br_cond = rs1_data_i >= rs2_data_i;
      default: br_cond = 1'b0;
    endcase
  end

  always_comb begin
    res    = '0;
    taken  = 1'b0;
    target = pc_i + imm_i;
    case (opcode_i)
      OpcOp, OpcOpImm:    res = is_m ? (funct3_i[2] ? 32'h0 : mul_res) : alu_res;
      OpcLoad, OpcStore:  res = rs1_data_i + imm_i;
      OpcLui:             res = imm_i;
      OpcAuipc:           res = pc_i + imm_i;
      OpcJal: begin
        res   = pc_i + 32'd4;
        taken = 1'b1;
      end
      OpcJalr: begin
        res    = pc_i + 32'd4;
        target = (rs1_data_i + imm_i) & ~32'h1;
        taken  = 1'b1;
      end
      OpcBranch:          taken = br_cond;
      default:            res = '0;
    endcase
  end

  // Divider works on magnitudes; signs are reapplied on the final iteration.
  logic [32:0] rem_shift;
  logic        rem_ge;
  logic [31:0] rem_nxt, quo_nxt, div_quo, div_rem;

  assign sgn_div   = ~funct3_i[0];
  assign a_neg     = sgn_div & rs1_data_i[31];
  assign b_neg     = sgn_div & rs2_data_i[31];
  assign rem_shift = {rem_q, quo_q[31]};
  assign rem_ge    = rem_shift >= {1'b0, dvs_q};
  assign rem_nxt   = rem_ge ? 32'(rem_shift - {1'b0, dvs_q}) : rem_shift[31:0];
  assign quo_nxt   = {quo_q[30:0], rem_ge};
  assign div_quo   = div_zero_q ? 32'hFFFF_FFFF : (neg_quo_q ? -quo_nxt : quo_nxt);
  assign div_rem   = neg_rem_q ? -rem_nxt : rem_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= StIdle;
      cnt_q           <= '0;
      quo_q           <= '0;
      rem_q           <= '0;
      dvs_q           <= '0;
      div_data_q      <= '0;
      div_opc_q       <= '0;
      div_rd_q        <= '0;
      neg_quo_q       <= 1'b0;
      neg_rem_q       <= 1'b0;
      want_rem_q      <= 1'b0;
      div_zero_q      <= 1'b0;
      valid_o         <= 1'b0;
      opcode_o        <= BUBBLE_OPCODE;
      rd_o            <= '0;
      alu_result_o    <= '0;
      data_o          <= '0;
      branch_taken_o  <= 1'b0;
      branch_target_o <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (valid_i && DIV_EN && is_div) begin
            state_q        <= StBusy;
            cnt_q          <= '0;
            quo_q          <= a_neg ? -rs1_data_i : rs1_data_i;
            dvs_q          <= b_neg ? -rs2_data_i : rs2_data_i;
            rem_q          <= '0;
            neg_quo_q      <= a_neg ^ b_neg;
            neg_rem_q      <= a_neg;
            want_rem_q     <= funct3_i[1];
            div_zero_q     <= (rs2_data_i == 32'h0);
            div_data_q     <= rs2_data_i;
            div_opc_q      <= opcode_i;
            div_rd_q       <= rd_i;
            valid_o        <= 1'b0;
            opcode_o       <= BUBBLE_OPCODE;
            branch_taken_o <= 1'b0;
          end else if (valid_i) begin
            valid_o         <= 1'b1;
            opcode_o        <= opcode_i;
            rd_o            <= rd_i;
            alu_result_o    <= res;
            data_o          <= rs2_data_i;
            branch_taken_o  <= taken;
            branch_target_o <= target;
          end else begin
            valid_o        <= 1'b0;
            opcode_o       <= BUBBLE_OPCODE;
            branch_taken_o <= 1'b0;
          end
        end
        StBusy: begin
          quo_q <= quo_nxt;
          rem_q <= rem_nxt;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_q        <= StIdle;
            valid_o        <= 1'b1;
            opcode_o       <= div_opc_q;
            rd_o           <= div_rd_q;
            alu_result_o   <= want_rem_q ? div_rem : div_quo;
            data_o         <= div_data_q;
            branch_taken_o <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_execute.sv
// Scoreboard bench for execute: directed corner cases then randomized ops checked against a
// behavioural RV32IM model; a monitor pops expectations whenever valid_o is seen.
module tb_execute;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i, ready_o;
  logic [4:0]  opcode_i, rd_i;
  logic [2:0]  funct3_i;
  logic [6:0]  funct7_i;
  logic [31:0] pc_i, rs1_data_i, rs2_data_i, imm_i;
  logic        valid_o, branch_taken_o;
  logic [4:0]  opcode_o, rd_o;
  logic [31:0] alu_result_o, data_o, branch_target_o;

  execute dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o), .opcode_i(opcode_i),
    .funct3_i(funct3_i), .funct7_i(funct7_i), .rd_i(rd_i), .pc_i(pc_i),
    .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .imm_i(imm_i), .valid_o(valid_o),
    .opcode_o(opcode_o), .rd_o(rd_o), .alu_result_o(alu_result_o), .data_o(data_o),
    .branch_taken_o(branch_taken_o), .branch_target_o(branch_target_o)
  );

  always #5 clk = ~clk;

  localparam logic [4:0] OP = 5'b01100, OPI = 5'b00100, BR = 5'b11000, JALR = 5'b11001;
  localparam logic [4:0] BUBBLE = 5'b00100;

  typedef struct {
    logic [4:0]  opc;
    logic [4:0]  rd;
    logic [31:0] res;
    logic [31:0] data;
    logic        taken;
    logic [31:0] tgt;
    logic        chk_tgt;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];
  int   cyc = 0;
  int   busy_end = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [4:0] opc, input logic [2:0] f3,
                                 input logic [6:0] f7, input logic [4:0] rd,
                                 input logic [31:0] pc, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] imm);
    exp_t e;
    logic [31:0] ob, q, r;
    logic signed [63:0] sa, sb;
    logic [63:0] ua, ub, p;
    e.opc = opc; e.rd = rd; e.res = 32'h0; e.data = b; e.taken = 1'b0;
    e.tgt = pc + imm; e.chk_tgt = 1'b0; e.cyc = 0;
    case (opc)
      OP, OPI: begin
        ob = (opc == OP) ? b : imm;
        if (opc == OP && f7 == 7'h01) begin
          sa = $signed(a); sb = $signed(b); ua = {32'h0, a}; ub = {32'h0, b};
          if (!f3[2]) begin
            case (f3[1:0])
              2'd0, 2'd1: p = sa * sb;
              2'd2:       p = sa * $signed(ub);
              default:    p = ua * ub;
            endcase
            e.res = (f3 == 3'b000) ? p[31:0] : p[63:32];
          end else begin
            if (b == 32'h0) begin
              q = 32'hFFFF_FFFF; r = a;
            end else if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
              q = 32'h8000_0000; r = 32'h0;
            end else if (!f3[0]) begin
              q = $signed(a) / $signed(b); r = $signed(a) % $signed(b);
            end else begin
              q = a / b; r = a % b;
            end
            e.res = f3[1] ? r : q;
          end
        end else begin
          case (f3)
            3'd0: e.res = (opc == OP && f7[5]) ? a - ob : a + ob;
            3'd1: e.res = a << ob[4:0];
            3'd2: e.res = ($signed(a) < $signed(ob)) ? 32'd1 : 32'd0;
            3'd3: e.res = (a < ob) ? 32'd1 : 32'd0;
            3'd4: e.res = a ^ ob;
            3'd5: begin
              sa = $signed(a);
              e.res = f7[5] ? 32'(sa >>> ob[4:0]) : a >> ob[4:0];
            end
            3'd6: e.res = a | ob;
            default: e.res = a & ob;
          endcase
        end
      end
      5'b00000, 5'b01000: e.res = a + imm;
      5'b01101: e.res = imm;
      5'b00101: e.res = pc + imm;
      5'b11011: begin e.res = pc + 4; e.taken = 1'b1; e.chk_tgt = 1'b1; end
      JALR: begin
        e.res = pc + 4; e.tgt = (a + imm) & 32'hFFFF_FFFE; e.taken = 1'b1; e.chk_tgt = 1'b1;
      end
      BR: begin
        e.chk_tgt = 1'b1;
        case (f3)
          3'd0: e.taken = (a == b);
          3'd1: e.taken = (a != b);
          3'd4: e.taken = ($signed(a) < $signed(b));
          3'd5: e.taken = ($signed(a) >= $signed(b));
          3'd6: e.taken = (a < b);
          3'd7: e.taken = (a >= b);
          default: e.taken = 1'b0;
        endcase
      end
      default: ;
    endcase
    return e;
  endfunction

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input logic [4:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [4:0] rd, input logic [31:0] pc, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] imm, input bit push);
    exp_t e;
    int   w = 0;
    bit   isdiv;
    opcode_i = opc; funct3_i = f3; funct7_i = f7; rd_i = rd; pc_i = pc;
    rs1_data_i = a; rs2_data_i = b; imm_i = imm; valid_i = 1'b1;
    while (!ready_o && w < 100) begin @(posedge clk); #1; w++; end
    if (!ready_o) begin
      n_chk++; n_fail++;
      $display("FAIL ready_timeout: ready_o %b required 1", ready_o);
      valid_i = 1'b0;
      return;
    end
    @(posedge clk); #1;
    valid_i = 1'b0;
    isdiv = (opc == OP) && (f7 == 7'h01) && f3[2];
    if (push) begin
      e = model(opc, f3, f7, rd, pc, a, b, imm);
      e.cyc = isdiv ? cyc + 32 : cyc;
      sb_q.push_back(e);
    end
    if (isdiv) busy_end = cyc + 32;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  function automatic logic [31:0] rv();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (valid_o) begin
          if (sb_q.size() == 0) begin
            chk("unexpected_valid", {31'b0, valid_o}, 32'h0);
          end else begin
            e = sb_q.pop_front();
            chk("latency", cyc, e.cyc);
            chk("opcode", {27'b0, opcode_o}, {27'b0, e.opc});
            chk("rd", {27'b0, rd_o}, {27'b0, e.rd});
            chk("result", alu_result_o, e.res);
            chk("data", data_o, e.data);
            chk("taken", {31'b0, branch_taken_o}, {31'b0, e.taken});
            if (e.chk_tgt) chk("target", branch_target_o, e.tgt);
          end
        end else begin
          chk("bubble_opcode", {27'b0, opcode_o}, {27'b0, BUBBLE});
          chk("bubble_taken", {31'b0, branch_taken_o}, 32'h0);
        end
        chk("ready", {31'b0, ready_o}, (cyc >= busy_end) ? 32'd1 : 32'd0);
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    logic [4:0]  opcs [10];
    logic [6:0]  f7s [3];
    logic [4:0]  opc;
    int          w;
    opcs = '{5'b00000, 5'b01000, OPI, OP, 5'b01101, 5'b00101, 5'b11011, JALR, BR, 5'b00011};
    f7s  = '{7'h00, 7'h20, 7'h01};
    rst = 1'b1; valid_i = 1'b0; opcode_i = '0; funct3_i = '0; funct7_i = '0; rd_i = '0;
    pc_i = '0; rs1_data_i = '0; rs2_data_i = '0; imm_i = '0;
    idle(3);
    rst = 1'b0;
    chk("rst_valid", {31'b0, valid_o}, 32'h0);
    chk("rst_opcode", {27'b0, opcode_o}, {27'b0, BUBBLE});
    chk("rst_rd", {27'b0, rd_o}, 32'h0);
    chk("rst_result", alu_result_o, 32'h0);
    chk("rst_data", data_o, 32'h0);
    chk("rst_taken", {31'b0, branch_taken_o}, 32'h0);
    chk("rst_target", branch_target_o, 32'h0);
    chk("rst_ready", {31'b0, ready_o}, 32'd1);
    mon_en = 1'b1;

    send(OP, 3'b000, 7'h00, 5'd3, 32'h0, 32'd7, 32'hFFFF_FFFF, 32'h0, 1'b1);
    chk("add_ready", {31'b0, ready_o}, 32'd1);
    send(OP, 3'b100, 7'h01, 5'd4, 32'h0, 32'hFFFF_FFF9, 32'd2, 32'h0, 1'b1);
    send(OP, 3'b110, 7'h01, 5'd5, 32'h0, 32'hFFFF_FFF9, 32'd2, 32'h0, 1'b1);
    send(OP, 3'b101, 7'h01, 5'd6, 32'h0, 32'd5, 32'h0, 32'h0, 1'b1);
    send(OP, 3'b111, 7'h01, 5'd7, 32'h0, 32'd5, 32'h0, 32'h0, 1'b1);
    send(OP, 3'b100, 7'h01, 5'd8, 32'h0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1'b1);
    send(BR, 3'b100, 7'h00, 5'd0, 32'h100, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFF0, 1'b1);
    send(BR, 3'b110, 7'h00, 5'd0, 32'h100, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFF0, 1'b1);
    send(JALR, 3'b000, 7'h00, 5'd1, 32'h40, 32'h1003, 32'h0, 32'd4, 1'b1);
    idle(4);

    // Abandon a divide with reset at E10.
    send(OP, 3'b100, 7'h01, 5'd9, 32'h0, 32'd100, 32'd3, 32'h0, 1'b0);
    idle(9);
    rst = 1'b1;
    busy_end = cyc + 1;
    idle(1);
    rst = 1'b0;
    chk("rstdiv_valid", {31'b0, valid_o}, 32'h0);
    chk("rstdiv_opcode", {27'b0, opcode_o}, {27'b0, BUBBLE});
    chk("rstdiv_ready", {31'b0, ready_o}, 32'd1);
    idle(3);

    for (int i = 0; i < 250; i++) begin
      opc = ($urandom_range(0, 3) == 0) ? OP : opcs[$urandom_range(0, 9)];
      send(opc, 3'($urandom_range(0, 7)), f7s[$urandom_range(0, 2)], 5'($urandom),
           $urandom & 32'hFFFF_FFFC, rv(), rv(), rv(), 1'b1);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end

    w = 0;
    while (sb_q.size() != 0 && w < 100) begin idle(1); w++; end
    chk("drain", sb_q.size(), 32'h0);
    idle(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
